// File: rtl/multi_channel_decim_delay.sv
// Multi-channel decimator (keep every Nth valid beat) followed by a programmable
// delay line of 0..DEPTH kept-sample periods with a registered, strobed output.
module multi_channel_decim_delay #(
   parameter int CHANNELS = 7,
   parameter int WIDTH    = 12,
   parameter int DEPTH    = 4,
   parameter int DECIM_W  = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          in_valid,
   input  logic [CHANNELS*WIDTH-1:0]     in_data,
   input  logic [DECIM_W-1:0]            decim,
   input  logic [$clog2(DEPTH+1)-1:0]    delay_sel,
   output logic                          out_valid,
   output logic [CHANNELS*WIDTH-1:0]     out_data
);

   localparam int DW    = CHANNELS * WIDTH;
   localparam int SEL_W = $clog2(DEPTH + 1);
   localparam logic [SEL_W-1:0] DEPTH_SEL = SEL_W'(DEPTH);

   logic [DECIM_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0]   fill_q, fill_d;
   logic               out_valid_q, out_valid_d;
   logic [DW-1:0]      out_data_q, out_data_d;
   logic [DW-1:0]      stage_q [DEPTH];
   logic [DW-1:0]      stage_d [DEPTH];

   logic [DECIM_W-1:0] neff_m1;
   logic               kept;
   logic [SEL_W-1:0]   d_eff;
   logic               primed;
   logic [DW-1:0]      sel_data;

   // ">=" rather than "==" so a run-time drop in decim cannot lock the counter out
   assign neff_m1 = (decim == '0) ? '0 : decim - 1'b1;
   assign kept    = in_valid && (cnt_q >= neff_m1);
   assign d_eff   = (delay_sel > DEPTH_SEL) ? DEPTH_SEL : delay_sel;
   assign primed  = (d_eff == '0) || (fill_q >= d_eff);

   always_comb begin
      sel_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (d_eff == SEL_W'(k + 1)) sel_data = stage_q[k];
      end
   end

   always_comb begin
      cnt_d       = cnt_q;
      fill_d      = fill_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      stage_d     = stage_q;
      if (flush) begin
         cnt_d      = '0;
         fill_d     = '0;
         out_data_d = '0;
         for (int k = 0; k < DEPTH; k++) stage_d[k] = '0;
      end else if (in_valid) begin
         if (kept) begin
            cnt_d      = '0;
            stage_d[0] = in_data;
            for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
            if (fill_q != DEPTH_SEL) fill_d = fill_q + 1'b1;
            // Output taps the pre-shift stages: the sample kept d_eff beats ago
            if (primed) begin
               out_valid_d = 1'b1;
               out_data_d  = (d_eff == '0) ? in_data : sel_data;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q       <= '0;
         fill_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      end else begin
         cnt_q       <= cnt_d;
         fill_q      <= fill_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         for (int k = 0; k < DEPTH; k++) stage_q[k] <= stage_d[k];
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

endmodule
